// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared types, constants and address helpers for the HD44780 bus responder.
package lcd_hd44780_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLEAR} state_e;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISP,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } ins_e;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_s;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         BUF_DEPTH  = 32;

  // Instruction class is selected by the highest set bit of the opcode.
  function automatic ins_e ins_class(input logic [7:0] d);
    casez (d)
      8'b1???????: return INS_DDRAM;
      8'b01??????: return INS_CGRAM;
      8'b001?????: return INS_FUNC;
      8'b0001????: return INS_SHIFT;
      8'b00001???: return INS_DISP;
      8'b000001??: return INS_ENTRY;
      8'b0000001?: return INS_HOME;
      8'b00000001: return INS_CLEAR;
      default:     return INS_NOP;
    endcase
  endfunction

  // Buffer index: row from AC[6], column from the low nibble; other bits alias.
  function automatic logic [4:0] idx(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  // Cursor step with line wrap 0x0F->0x40->...->0x4F->0x00 (and reverse).
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac[3:0] == 4'hF) return ac[6] ? LINE1_BASE : LINE2_BASE;
      return {ac[6], 2'b00, ac[3:0] + 4'd1};
    end
    if (ac[3:0] == 4'h0) return (ac[6] ? LINE1_BASE : LINE2_BASE) | 7'h0F;
    return {ac[6:4], ac[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// Host-side LCD bus: strobe, register select, direction and both data paths.
interface lcd_hd44780_responder_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_data_in;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;

  modport master (output LCD_E, LCD_RS, LCD_RW, LCD_data_in,
                  input  LCD_data_out, LCD_data_oe);
  modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_data_in,
                  output LCD_data_out, LCD_data_oe);
endinterface

// File: rtl/lcd_hd44780_responder_bus_sampler.sv
// Synchronises the asynchronous LCD bus and flags the falling edge of E.
module lcd_bus_sampler
  import lcd_hd44780_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  output logic       commit_o,
  output logic       rd_active_o,
  output logic       rd_rs_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] data_o
);

  bus_s sync_q [SYNC_STAGES];
  bus_s prev_q;
  bus_s cur;

  assign cur = sync_q[SYNC_STAGES-1];

  // Synchroniser chain plus one extra stage holding the previous synced sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {e_i, rs_i, rw_i, data_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= cur;
    end
  end

  // Commit uses the sample taken while E was still high.
  assign commit_o    = prev_q.e & ~cur.e;
  assign rs_o        = prev_q.rs;
  assign rw_o        = prev_q.rw;
  assign data_o      = prev_q.data;
  assign rd_active_o = cur.e & cur.rw;
  assign rd_rs_o     = cur.rs;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780 device-side emulator: instruction decode, 2x16 DDRAM, AC and busy flag.
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 76000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd_hd44780_responder_if.slave  bus,
  input  logic [4:0]              disp_addr,
  output logic [7:0]              disp_char,
  output logic                    display_on,
  output logic                    busy
);

  localparam int MAXC = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic          commit, rd_active, rd_rs, s_rs, s_rw;
  logic [7:0]    s_data;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d, don_q, don_d;
  logic [5:0]    fill_q, fill_d;
  logic [7:0]    mem [BUF_DEPTH];
  logic [7:0]    disp_q;
  logic          mem_we;

  lcd_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .e_i        (bus.LCD_E),
    .rs_i       (bus.LCD_RS),
    .rw_i       (bus.LCD_RW),
    .data_i     (bus.LCD_data_in),
    .commit_o   (commit),
    .rd_active_o(rd_active),
    .rd_rs_o    (rd_rs),
    .rs_o       (s_rs),
    .rw_o       (s_rw),
    .data_o     (s_data)
  );

  assign busy       = (state_q != ST_IDLE);
  assign display_on = don_q;
  assign disp_char  = disp_q;

  // Control registers; reset always lands in a fresh clear sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CW'(CLEAR_CYCLES - 1);
      fill_q  <= '0;
      ac_q    <= LINE1_BASE;
      id_q    <= 1'b1;
      don_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      don_q   <= don_d;
    end
  end

  // Next state: decode commits in IDLE, count down in BUSY/CLEAR, drop writes otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    ac_d    = ac_q;
    id_d    = id_q;
    don_d   = don_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit && s_rw) begin
          if (s_rs) ac_d = ac_step(ac_q, id_q);
        end else if (commit && s_rs) begin
          mem_we  = 1'b1;
          ac_d    = ac_step(ac_q, id_q);
          state_d = ST_BUSY;
          cnt_d   = CW'(CMD_CYCLES - 1);
        end else if (commit) begin
          state_d = ST_BUSY;
          cnt_d   = CW'(CMD_CYCLES - 1);
          case (ins_class(s_data))
            INS_CLEAR: begin
              state_d = ST_CLEAR;
              cnt_d   = CW'(CLEAR_CYCLES - 1);
              fill_d  = '0;
              ac_d    = LINE1_BASE;
              id_d    = 1'b1;
            end
            INS_HOME:  ac_d  = LINE1_BASE;
            INS_ENTRY: id_d  = s_data[1];
            INS_DISP:  don_d = s_data[2];
            INS_SHIFT: if (!s_data[3]) ac_d = ac_step(ac_q, s_data[2]);
            INS_DDRAM: ac_d  = s_data[6:0];
            default: ;
          endcase
        end
      end
      ST_BUSY, ST_CLEAR: begin
        if (state_q == ST_CLEAR && !fill_q[5]) fill_d = fill_q + 6'd1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DDRAM write port: clear fill has priority (data writes cannot occur in CLEAR).
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR && !fill_q[5]) mem[fill_q[4:0]] <= CHAR_SPACE;
      else if (mem_we)                       mem[idx(ac_q)]   <= s_data;
    end
  end

  // Display-side read port, one cycle latency.
  always_ff @(posedge clk) begin
    if (reset) disp_q <= '0;
    else       disp_q <= mem[disp_addr];
  end

  // Bus read mux: status or DDRAM while a synced read strobe is active.
  always_comb begin
    bus.LCD_data_oe  = rd_active;
    bus.LCD_data_out = '0;
    if (rd_active) bus.LCD_data_out = rd_rs ? mem[idx(ac_q)] : {busy, ac_q};
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboarded random/directed bench for the HD44780 responder.
module tb_lcd_hd44780_responder;
  localparam int CMD  = 20;
  localparam int CLR  = 64;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] disp_addr = '0;
  logic [7:0] disp_char;
  logic       display_on, busy;

  lcd_hd44780_responder_if bus_if();

  lcd_hd44780_responder #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .disp_addr(disp_addr),
    .disp_char(disp_char), .display_on(display_on), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {string name; logic [7:0] exp;} exp_t;
  exp_t rd_q[$];
  exp_t disp_q[$];
  exp_t rx;
  int   n_tests = 0, n_fail = 0;
  logic disp_chk = 1'b0;
  logic oe_prev = 1'b0;
  int   e_low = 0;

  // Reference model: cursor as a linear position 0..31 over both lines.
  int         m_pos;
  bit         m_id, m_don;
  logic [7:0] m_buf [32];

  function automatic int step(int p, bit inc);
    return inc ? (p + 1) % 32 : (p + 31) % 32;
  endfunction
  function automatic logic [6:0] pos2ac(int p);
    return 7'((p >= 16 ? 'h40 : 0) + p % 16);
  endfunction
  function automatic int ac2pos(logic [6:0] a);
    return (a[6] ? 16 : 0) + int'(a[3:0]);
  endfunction

  function automatic void check(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_pos = 0; m_id = 1; m_don = 0;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
  endtask

  // Monitor: pops expectations whenever the DUT presents read or display data.
  always @(negedge clk) begin
    if (bus_if.LCD_E) e_low = 0; else e_low++;
    if (bus_if.LCD_data_oe && !oe_prev) begin
      if (rd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_read: got %02h expected none", bus_if.LCD_data_out);
      end else begin
        rx = rd_q.pop_front();
        check(rx.name, bus_if.LCD_data_out, rx.exp);
      end
    end
    if (bus_if.LCD_data_oe && e_low > SYNC + 1)
      check("oe_while_E_low", {7'b0, bus_if.LCD_data_oe}, 8'h00);
    if (disp_chk) begin
      if (disp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_disp: got %02h expected none", disp_char);
      end else begin
        rx = disp_q.pop_front();
        check(rx.name, disp_char, rx.exp);
      end
    end
    oe_prev = bus_if.LCD_data_oe;
  end

  task automatic bus_cycle(bit rs, bit rw, logic [7:0] d);
    @(posedge clk); #1;
    bus_if.LCD_RS = rs; bus_if.LCD_RW = rw; bus_if.LCD_data_in = d; bus_if.LCD_E = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus_if.LCD_E = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge clk); k++; end while (busy !== 1'b0 && k < CLR * 4);
    if (busy !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL busy_timeout: got busy=%b expected 0", busy);
    end
  endtask

  task automatic wr_cmd(logic [7:0] d);
    bus_cycle(1'b0, 1'b0, d);
    if (d[7])               m_pos = ac2pos(d[6:0]);
    else if (d[6] || d[5])  ;
    else if (d[4])          begin if (!d[3]) m_pos = step(m_pos, d[2]); end
    else if (d[3])          m_don = d[2];
    else if (d[2])          m_id  = d[1];
    else if (d[1])          m_pos = 0;
    else if (d[0])          begin m_pos = 0; m_id = 1; for (int i = 0; i < 32; i++) m_buf[i] = 8'h20; end
    wait_idle();
  endtask

  task automatic wr_data(logic [7:0] d);
    bus_cycle(1'b1, 1'b0, d);
    m_buf[m_pos] = d;
    m_pos = step(m_pos, m_id);
    wait_idle();
  endtask

  task automatic rd_status(string nm, bit bf);
    exp_t e;
    e.name = nm; e.exp = {bf, pos2ac(m_pos)};
    rd_q.push_back(e);
    bus_cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic rd_data(string nm);
    exp_t e;
    e.name = nm; e.exp = m_buf[m_pos];
    rd_q.push_back(e);
    bus_cycle(1'b1, 1'b1, 8'h00);
    m_pos = step(m_pos, m_id);
  endtask

  task automatic chk_disp(int a);
    exp_t e;
    @(posedge clk); #1 disp_addr = 5'(a);
    @(posedge clk); #1;
    e.name = $sformatf("disp_%0d", a); e.exp = m_buf[a];
    disp_q.push_back(e);
    disp_chk = 1'b1;
    @(negedge clk); #1 disp_chk = 1'b0;
  endtask

  task automatic chk_all();
    for (int a = 0; a < 32; a++) chk_disp(a);
  endtask

  task automatic reset_and_measure(string nm);
    int cnt = 0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({nm, "_rst_busy"}, {7'b0, busy}, 8'h01);
    check({nm, "_rst_oe"}, {7'b0, bus_if.LCD_data_oe}, 8'h00);
    check({nm, "_rst_dout"}, bus_if.LCD_data_out, 8'h00);
    check({nm, "_rst_disp_char"}, disp_char, 8'h00);
    check({nm, "_rst_display_on"}, {7'b0, display_on}, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    while (1) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
      if (cnt > CLR * 4) break;
    end
    n_tests++;
    if (cnt != CLR) begin
      n_fail++;
      $display("FAIL %s_busy_len: got %0d cycles expected %0d", nm, cnt, CLR);
    end
  endtask

  initial begin
    bus_if.LCD_E = 1'b0; bus_if.LCD_RS = 1'b0; bus_if.LCD_RW = 1'b0; bus_if.LCD_data_in = '0;
    model_reset();
    reset_and_measure("por");
    chk_all();
    check("por_display_on", {7'b0, display_on}, {7'b0, m_don});

    // Display on, home via Set DDRAM, write "HI".
    wr_cmd(8'h0C);
    check("display_on_set", {7'b0, display_on}, {7'b0, m_don});
    wr_cmd(8'h80); wr_data(8'h48); wr_data(8'h49);
    chk_disp(0); chk_disp(1);
    rd_status("status_HI", 1'b0);

    // Line 1 -> line 2 wrap on increment.
    wr_cmd(8'h8F); wr_data(8'h41); wr_data(8'h42);
    chk_disp(15); chk_disp(16);
    rd_status("status_wrap_inc", 1'b0);

    // Decrement mode wraps 0x00 -> 0x4F.
    wr_cmd(8'h04); wr_cmd(8'h80); wr_data(8'h5A);
    chk_disp(0);
    rd_status("status_wrap_dec", 1'b0);

    // Writes during busy are dropped; status read shows BF.
    wr_cmd(8'h06); wr_cmd(8'h80);
    bus_cycle(1'b1, 1'b0, 8'h33);
    m_buf[m_pos] = 8'h33; m_pos = step(m_pos, m_id);
    bus_cycle(1'b1, 1'b0, 8'h77);
    rd_status("status_busy", 1'b1);
    @(negedge clk);
    check("oe_after_read", {7'b0, bus_if.LCD_data_oe}, 8'h00);
    check("dout_after_read", bus_if.LCD_data_out, 8'h00);
    wait_idle();
    chk_disp(0); chk_disp(1);
    rd_status("status_after_drop", 1'b0);

    // Randomised instruction/data mix.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1: wr_data(8'($urandom_range(32, 126)));
        2:    wr_cmd({1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom_range(0, 15))});
        3:    wr_cmd({6'b000001, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        4:    wr_cmd({4'b0001, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))});
        5:    wr_cmd({5'b00001, 3'($urandom_range(0, 7))});
        6:    wr_cmd($urandom_range(0, 1) ? {3'b001, 5'($urandom_range(0, 31))} : {2'b01, 6'($urandom_range(0, 63))});
        7:    rd_data($sformatf("rand_rd_%0d", i));
        8:    rd_status($sformatf("rand_status_%0d", i), 1'b0);
        default: begin
          if ($urandom_range(0, 3) == 0) wr_cmd({7'b0000001, 1'($urandom_range(0, 1))});
          chk_disp(m_pos);
          check($sformatf("rand_display_on_%0d", i), {7'b0, display_on}, {7'b0, m_don});
        end
      endcase
    end
    chk_all();

    // Clear command interrupted by reset: full clear restarts.
    bus_cycle(1'b0, 1'b0, 8'h01);
    repeat (10) @(posedge clk);
    model_reset();
    reset_and_measure("midclear");
    chk_all();
    rd_status("status_after_clear", 1'b0);
    check("display_on_after_clear", {7'b0, display_on}, {7'b0, m_don});

    repeat (5) @(posedge clk);
    check("rd_queue_drained", 8'(rd_q.size()), 8'h00);
    check("disp_queue_drained", 8'(disp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
